paddle_ctrl: RTL
================

Name: paddle_ctrl

Overview:
Parametrised next-generation paddle controller for the pong datapath. Outputs the upper-left X/Y of one paddle. Supports manual up/down control with hold-to-accelerate speed ramping, and an AI mode with reaction delay, deadband, overshoot-free tracking and return-to-centre. Motion advances only on a frame tick, so speed is independent of clk rate; one instance per side.

Parameters:
SCREEN_W, 640, playfield width in pixels
SCREEN_H, 480, playfield height in pixels
X_W, 10, width of X coordinates
Y_W, 9, width of Y coordinates
MAX_SPEED, 6, maximum step in pixels per tick (>=1)
ACCEL_DIV, 4, consecutive moving ticks per +1 speed increment (>=1)
AI_DELAY, 3, ticks the AI waits after the ball turns toward it
AI_DEADBAND, 2, AI does not move while |paddle centre - ball_y| <= this

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
tick  in  1  one-cycle frame strobe; all motion occurs on tick cycles
side  in  1  1 = left paddle, 0 = right paddle
ai_ctrl  in  1  1 = AI mode, 0 = manual mode
up  in  1  manual move up
down  in  1  manual move down
width  in  6  paddle width
wall_width  in  6  top/bottom wall thickness
length  in  Y_W  paddle length
ball_y  in  Y_W  ball Y coordinate
ball_direction  in  1  1 = ball heading left, 0 = ball heading right
out_x  out  X_W  paddle X (registered)
out_y  out  Y_W  paddle Y (registered)
moving  out  1  1 if out_y changed on the last tick
state_o  out  3  current FSM state, for debug and LEDs

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values:
  - out_x = side ? 0 : SCREEN_W-width
  - out_y = (SCREEN_H-length)>>1
  - speed = 1, delay counter = 0, accel counter = 0
  - moving = 0, state = IDLE
- On non-tick cycles all registers hold.
- out_x is re-evaluated from side/width on every tick.
- Limits, computed with at least Y_W+1 bits and no wrap:
  - TOP = wall_width
  - BOT = SCREEN_H - wall_width - length
  - Every tick, out_y is clamped to [TOP, BOT], including after a length change.
- Upward moves:
  - If out_y < TOP + step, out_y = TOP.
  - Otherwise out_y = out_y - step.
- Downward moves:
  - If out_y + step > BOT, out_y = BOT.
  - Otherwise out_y = out_y + step.
- Speed ramp, shared by MAN_UP, MAN_DN and AI_TRACK:
  - The first moving tick in a direction uses speed 1.
  - After every ACCEL_DIV consecutive ticks moving in the same direction, speed increments, saturating at MAX_SPEED.
  - A direction change, a stop, a deadband hit or a mode change resets speed to 1 and clears the accel counter.
  - A tick clamped at a wall counts as stopped.
- FSM states: IDLE, MAN_UP, MAN_DN, AI_WAIT, AI_TRACK, AI_CENTER. Transitions are evaluated on tick.
- Manual mode (ai_ctrl=0):
  - up -> MAN_UP; else down -> MAN_DN; else IDLE. up wins when both are asserted.
- AI mode (ai_ctrl=1):
  - When ball_direction == side, enter AI_WAIT. Load the delay counter with AI_DELAY, decrement it each tick, and make no motion.
  - When the counter reaches 0 on a tick, move to AI_TRACK. With AI_DELAY=0, go directly to AI_TRACK.
  - AI_TRACK: centre = out_y + (length>>1) and d = |centre - ball_y|.
    - If d <= AI_DEADBAND, no move.
    - Otherwise step toward the ball by min(speed, d), so the paddle never overshoots.
  - When ball_direction != side (from any AI state), enter AI_CENTER.
    - Step 1 per tick toward centre = SCREEN_H>>1; hold once equal.
    - The ball turning back toward the paddle re-enters AI_WAIT with a fresh delay.
- Mode switches:
  - ai_ctrl toggling on a tick forces the new mode's entry state (IDLE, or AI_WAIT/AI_CENTER) and speed = 1.
  - ai_ctrl toggling between ticks is sampled at the next tick only.
- moving = (out_y_next != out_y), updated on tick.
- state_o encoding: IDLE=0, MAN_UP=1, MAN_DN=2, AI_WAIT=3, AI_TRACK=4, AI_CENTER=5.
- Reset asserted mid-motion immediately restores the reset values, without waiting for clk or tick.

Test Plan:
All scenarios use default parameters with length=80, wall_width=10, width=10, and tick every 4 clk.
- Reset, side=0 -> out_x=630, out_y=200, state_o=0, moving=0. Then set side=1 and apply one tick -> out_x=0.
- Manual: hold up for 8 ticks from out_y=200 -> out_y steps 199,198,197,196,194,192,190,188. Release -> speed returns to 1; next up tick gives 187.
- Wall clamp: out_y=12 with up held at speed 2 -> 10, then holds at 10 with moving=0 and speed reset. Both up and down held -> treated as up.
- AI delay: ai_ctrl=1, side=1, ball_direction goes 1 with ball_y=400 and out_y=200 -> ticks 1-3 out_y=200 (state 3); tick 4 out_y=201 (state 4).
- Deadband and no overshoot: centre=240, ball_y=242 -> no move; ball_y=243 -> move +1. At speed 6 with d=3 -> step exactly 3.
- Return-to-centre: out_y=203 and ball turns away -> 202, 201, 200, then holds (state 5). Assert reset between ticks mid-move -> out_y=200 and state 0 immediately.

Source files
------------

// File: rtl/paddle_ctrl.sv
// Paddle position controller: manual up/down with speed ramp, or AI tracking with
// reaction delay, deadband and return-to-centre. All motion happens on frame ticks.
module paddle_ctrl #(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int X_W         = 10,
    parameter int Y_W         = 9,
    parameter int MAX_SPEED   = 6,
    parameter int ACCEL_DIV   = 4,
    parameter int AI_DELAY    = 3,
    parameter int AI_DEADBAND = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           tick,
    input  logic           side,
    input  logic           ai_ctrl,
    input  logic           up,
    input  logic           down,
    input  logic [5:0]     width,
    input  logic [5:0]     wall_width,
    input  logic [Y_W-1:0] length,
    input  logic [Y_W-1:0] ball_y,
    input  logic           ball_direction,
    output logic [X_W-1:0] out_x,
    output logic [Y_W-1:0] out_y,
    output logic           moving,
    output logic [2:0]     state_o
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MAN_UP    = 3'd1,
        MAN_DN    = 3'd2,
        AI_WAIT   = 3'd3,
        AI_TRACK  = 3'd4,
        AI_CENTER = 3'd5
    } state_t;

    // Two guard bits keep limit arithmetic signed and wrap-free.
    localparam int W     = Y_W + 2;
    localparam int DLY_W = $clog2(AI_DELAY + 2);
    localparam int SPD_W = $clog2(MAX_SPEED + 2);
    localparam int ACC_W = $clog2(ACCEL_DIV + 2);

    localparam logic [1:0] DIR_NONE = 2'd0;
    localparam logic [1:0] DIR_UP   = 2'd1;
    localparam logic [1:0] DIR_DN   = 2'd2;

    localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(AI_DELAY);
    localparam logic [DLY_W-1:0] DLY_ONE  = DLY_W'(1);
    localparam logic [SPD_W-1:0] SPD_ONE  = SPD_W'(1);
    localparam logic [SPD_W-1:0] SPD_MAX  = SPD_W'(MAX_SPEED);
    localparam logic [ACC_W-1:0] ACC_LAST = ACC_W'(ACCEL_DIV - 1);
    localparam logic [ACC_W-1:0] ACC_ONE  = ACC_W'(1);

    localparam logic signed [W-1:0] SCREEN_H_S = W'(SCREEN_H);
    localparam logic signed [W-1:0] HALF_H_S   = W'(SCREEN_H / 2);
    localparam logic signed [W-1:0] DB_S       = W'(AI_DEADBAND);
    localparam logic signed [W-1:0] ONE_S      = W'(1);
    localparam logic signed [W-1:0] CAP_MAX_S  = W'(MAX_SPEED);

    state_t             state_reg, state_next;
    logic [DLY_W-1:0]   delay_reg, delay_next;
    logic [SPD_W-1:0]   speed_reg, speed_next, base_speed;
    logic [ACC_W-1:0]   accel_reg, accel_next, base_accel;
    logic [1:0]         dir_reg, dir_next, req_dir;
    logic [X_W-1:0]     x_init;
    logic [Y_W-1:0]     y_init, y_next;
    logic               toward, ramped, clamped, same_dir;

    logic signed [W-1:0] top_s, bot_s, len_s, ball_s, y_init_s;
    logic signed [W-1:0] y_clamp_s, centre_s, diff_s, cap_s, step_s, y_new_s;

    assign len_s    = $signed(W'(length));
    assign ball_s   = $signed(W'(ball_y));
    assign top_s    = $signed(W'(wall_width));
    assign bot_s    = SCREEN_H_S - top_s - len_s;
    assign y_init_s = (SCREEN_H_S - len_s) >>> 1;
    assign y_init   = y_init_s[Y_W-1:0];
    assign x_init   = side ? '0 : (X_W'(SCREEN_W) - X_W'(width));
    assign toward   = (ball_direction == side);
    assign state_o  = state_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else if (tick) begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        delay_next = delay_reg;
        if (!ai_ctrl) begin
            delay_next = '0;
            if (up) begin
                state_next = MAN_UP;
            end else if (down) begin
                state_next = MAN_DN;
            end else begin
                state_next = IDLE;
            end
        end else if (!toward) begin
            state_next = AI_CENTER;
            delay_next = '0;
        end else if (state_reg == AI_WAIT) begin
            if (delay_reg <= DLY_ONE) begin
                state_next = AI_TRACK;
                delay_next = '0;
            end else begin
                delay_next = delay_reg - DLY_ONE;
            end
        end else if (state_reg == AI_TRACK) begin
            state_next = AI_TRACK;
            delay_next = '0;
        end else if (AI_DELAY == 0) begin
            state_next = AI_TRACK;
            delay_next = '0;
        end else begin
            // Entering from manual mode or from centring: start a fresh reaction delay.
            state_next = AI_WAIT;
            delay_next = DLY_LOAD;
        end
    end

    always_comb begin
        y_clamp_s = $signed(W'(out_y));
        if (y_clamp_s > bot_s) begin
            y_clamp_s = bot_s;
        end
        if (y_clamp_s < top_s) begin
            y_clamp_s = top_s;
        end
        centre_s = y_clamp_s + (len_s >>> 1);
        diff_s   = centre_s - ball_s;
        req_dir  = DIR_NONE;
        ramped   = 1'b0;
        cap_s    = CAP_MAX_S;
        case (state_next)
            MAN_UP: begin
                req_dir = DIR_UP;
                ramped  = 1'b1;
            end
            MAN_DN: begin
                req_dir = DIR_DN;
                ramped  = 1'b1;
            end
            AI_TRACK: begin
                // Capping the step at the distance prevents overshooting the ball.
                if (diff_s > DB_S) begin
                    req_dir = DIR_UP;
                    ramped  = 1'b1;
                    cap_s   = diff_s;
                end else if (diff_s < -DB_S) begin
                    req_dir = DIR_DN;
                    ramped  = 1'b1;
                    cap_s   = -diff_s;
                end
            end
            AI_CENTER: begin
                if (centre_s > HALF_H_S) begin
                    req_dir = DIR_UP;
                end else if (centre_s < HALF_H_S) begin
                    req_dir = DIR_DN;
                end
            end
            default: req_dir = DIR_NONE;
        endcase

        same_dir   = ramped && (req_dir == dir_reg);
        base_speed = same_dir ? speed_reg : SPD_ONE;
        base_accel = same_dir ? accel_reg : '0;
        step_s     = ramped ? $signed(W'(base_speed)) : ONE_S;
        if (step_s > cap_s) begin
            step_s = cap_s;
        end

        y_new_s = y_clamp_s;
        clamped = 1'b0;
        if (req_dir == DIR_UP) begin
            if (y_clamp_s < top_s + step_s) begin
                y_new_s = top_s;
                clamped = 1'b1;
            end else begin
                y_new_s = y_clamp_s - step_s;
            end
        end else if (req_dir == DIR_DN) begin
            if (y_clamp_s + step_s > bot_s) begin
                y_new_s = bot_s;
                clamped = 1'b1;
            end else begin
                y_new_s = y_clamp_s + step_s;
            end
        end
        y_next = y_new_s[Y_W-1:0];

        // Wall hits, deadband, centring and idle all restart the ramp from speed 1.
        if (ramped && !clamped) begin
            dir_next = req_dir;
            if (base_accel >= ACC_LAST) begin
                accel_next = '0;
                speed_next = (base_speed >= SPD_MAX) ? SPD_MAX : base_speed + SPD_ONE;
            end else begin
                accel_next = base_accel + ACC_ONE;
                speed_next = base_speed;
            end
        end else begin
            dir_next   = DIR_NONE;
            accel_next = '0;
            speed_next = SPD_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_x     <= x_init;
            out_y     <= y_init;
            speed_reg <= SPD_ONE;
            accel_reg <= '0;
            dir_reg   <= DIR_NONE;
            delay_reg <= '0;
            moving    <= 1'b0;
        end else if (tick) begin
            out_x     <= x_init;
            out_y     <= y_next;
            speed_reg <= speed_next;
            accel_reg <= accel_next;
            dir_reg   <= dir_next;
            delay_reg <= delay_next;
            moving    <= (y_next != out_y);
        end
    end

endmodule
